// File: rtl/countdown_timer.sv
// Minutes/seconds countdown timer with load, start/stop control and a sticky expiry flag.
// One-second ticks come from a prescaler that divides clk by TICK_DIV while running.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  input  logic       start,
  input  logic       stop,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done,
  output logic       done_pulse
);

  localparam int unsigned PW = 16;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0] MAX_VAL = 6'd59;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [5:0]    min_nxt, sec_nxt;
  logic          running_nxt, done_nxt, done_pulse_nxt;
  logic          tick, count_nonzero;

  assign tick          = (presc == TICK_LAST);
  assign count_nonzero = (min != 6'd0) || (sec != 6'd0);

  // Next-state and next-output logic; load dominates, then start/stop, then tick.
  always_comb begin
    state_nxt      = state;
    presc_nxt      = presc;
    min_nxt        = min;
    sec_nxt        = sec;
    done_nxt       = done;
    done_pulse_nxt = 1'b0;

    if (load) begin
      state_nxt = IDLE;
      min_nxt   = (set_min > MAX_VAL) ? MAX_VAL : set_min;
      sec_nxt   = (set_sec > MAX_VAL) ? MAX_VAL : set_sec;
      done_nxt  = 1'b0;
      presc_nxt = '0;
    end else begin
      case (state)
        IDLE, PAUSE: begin
          if (start) begin
            if (count_nonzero) begin
              state_nxt = RUN;
              presc_nxt = '0;
            end else begin
              state_nxt      = DONE;
              done_nxt       = 1'b1;
              done_pulse_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_nxt = PAUSE;
          end else if (tick) begin
            presc_nxt = '0;
            if (sec != 6'd0) begin
              sec_nxt = sec - 6'd1;
            end else if (min != 6'd0) begin
              sec_nxt = MAX_VAL;
              min_nxt = min - 6'd1;
            end
            // Final tick lands on 00:00 and expires on the same edge.
            if (min == 6'd0 && sec <= 6'd1) begin
              state_nxt      = DONE;
              done_nxt       = 1'b1;
              done_pulse_nxt = 1'b1;
            end
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        default: ;
      endcase
    end

    running_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      presc      <= '0;
      min        <= 6'd0;
      sec        <= 6'd0;
      running    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      min        <= min_nxt;
      sec        <= sec_nxt;
      running    <= running_nxt;
      done       <= done_nxt;
      done_pulse <= done_pulse_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus randomized traffic against a
// remaining-seconds reference model, on TICK_DIV=1 and TICK_DIV=4 instances.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_n, load, start, stop;
  logic [5:0] set_min, set_sec;

  logic [5:0] d_min[2];
  logic [5:0] d_sec[2];
  logic       d_run[2];
  logic       d_done[2];
  logic       d_pulse[2];

  int errors = 0;
  int checks = 0;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  int m_st[2], m_rem[2], m_elapsed[2];
  bit m_done[2], m_pulse[2];
  int div[2] = '{1, 4};

  always #5 clk = ~clk;

  countdown_timer #(.TICK_DIV(1)) u_div1 (
    .clk(clk), .reset_n(reset_n), .load(load), .set_min(set_min), .set_sec(set_sec),
    .start(start), .stop(stop), .min(d_min[0]), .sec(d_sec[0]), .running(d_run[0]),
    .done(d_done[0]), .done_pulse(d_pulse[0])
  );

  countdown_timer #(.TICK_DIV(4)) u_div4 (
    .clk(clk), .reset_n(reset_n), .load(load), .set_min(set_min), .set_sec(set_sec),
    .start(start), .stop(stop), .min(d_min[1]), .sec(d_sec[1]), .running(d_run[1]),
    .done(d_done[1]), .done_pulse(d_pulse[1])
  );

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE; m_rem[i] = 0; m_elapsed[i] = 0; m_done[i] = 0; m_pulse[i] = 0;
    end
  endfunction

  // Remaining time kept as total seconds; a tick fires after div cycles spent in RUN.
  function automatic void model_step();
    int cm, cs;
    cm = (set_min > 59) ? 59 : int'(set_min);
    cs = (set_sec > 59) ? 59 : int'(set_sec);
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 0;
      if (load) begin
        m_st[i] = S_IDLE; m_rem[i] = cm * 60 + cs; m_done[i] = 0; m_elapsed[i] = 0;
      end else if ((m_st[i] == S_IDLE || m_st[i] == S_PAUSE) && start) begin
        if (m_rem[i] > 0) begin
          m_st[i] = S_RUN; m_elapsed[i] = 0;
        end else begin
          m_st[i] = S_DONE; m_done[i] = 1; m_pulse[i] = 1;
        end
      end else if (m_st[i] == S_RUN && stop) begin
        m_st[i] = S_PAUSE;
      end else if (m_st[i] == S_RUN) begin
        m_elapsed[i]++;
        if (m_elapsed[i] == div[i]) begin
          m_elapsed[i] = 0;
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_st[i] = S_DONE; m_done[i] = 1; m_pulse[i] = 1;
          end
        end
      end
    end
  endfunction

  task automatic clk_step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit l, input bit st, input bit sp, input int sm, input int ss);
    load = l; start = st; stop = sp; set_min = 6'(sm); set_sec = 6'(ss);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({d_min[i], d_sec[i], d_run[i], d_done[i], d_pulse[i]} !== 15'd0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %0d:%0d run=%b done=%b pulse=%b want all 0",
                 i, d_min[i], d_sec[i], d_run[i], d_done[i], d_pulse[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    clk_step();
    checks++;
    if (d_run[0] !== 1'b0 || d_min[0] !== 6'd0 || d_sec[0] !== 6'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got %0d:%0d run=%b want 0:0 run=0", d_min[0], d_sec[0], d_run[0]);
    end
  endtask

  task automatic test_one_minute();
    int np = 0;
    drive(1, 0, 0, 1, 0);
    clk_step();
    checks++;
    if (d_min[0] !== 6'd1 || d_sec[0] !== 6'd0 || d_run[0] !== 1'b0) begin
      errors++;
      $display("FAIL load_0100: got %0d:%0d run=%b want 1:0 run=0", d_min[0], d_sec[0], d_run[0]);
    end
    drive(0, 1, 0, 0, 0);
    clk_step();
    checks++;
    if (d_min[0] !== 6'd1 || d_sec[0] !== 6'd0 || d_run[0] !== 1'b1) begin
      errors++;
      $display("FAIL start_no_dec: got %0d:%0d run=%b want 1:0 run=1", d_min[0], d_sec[0], d_run[0]);
    end
    drive(0, 0, 0, 0, 0);
    for (int n = 1; n <= 62; n++) begin
      clk_step();
      if (d_pulse[0] === 1'b1) np++;
      if (n == 1) begin
        checks++;
        if (d_min[0] !== 6'd0 || d_sec[0] !== 6'd59) begin
          errors++;
          $display("FAIL first_tick: got %0d:%0d want 0:59", d_min[0], d_sec[0]);
        end
      end
      if (n == 59) begin
        checks++;
        if (d_sec[0] !== 6'd1 || d_done[0] !== 1'b0 || d_run[0] !== 1'b1) begin
          errors++;
          $display("FAIL at_0001: got sec=%0d done=%b run=%b want 1 0 1", d_sec[0], d_done[0], d_run[0]);
        end
      end
      if (n == 60) begin
        checks++;
        if (d_sec[0] !== 6'd0 || d_done[0] !== 1'b1 || d_pulse[0] !== 1'b1 || d_run[0] !== 1'b0) begin
          errors++;
          $display("FAIL expire_k60: got sec=%0d done=%b pulse=%b run=%b want 0 1 1 0",
                   d_sec[0], d_done[0], d_pulse[0], d_run[0]);
        end
      end
    end
    checks++;
    if (np != 1 || d_done[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse: got pulses=%0d done=%b want 1 1", np, d_done[0]);
    end
  endtask

  task automatic test_pause_resume();
    drive(1, 0, 0, 0, 3);
    clk_step();
    drive(0, 1, 1, 0, 0);
    clk_step();
    checks++;
    if (d_run[0] !== 1'b1 || d_sec[0] !== 6'd3) begin
      errors++;
      $display("FAIL start_with_stop: got run=%b sec=%0d want 1 3", d_run[0], d_sec[0]);
    end
    drive(0, 0, 0, 0, 0);
    clk_step();
    drive(0, 1, 1, 0, 0);
    clk_step();
    checks++;
    if (d_run[0] !== 1'b0 || d_sec[0] !== 6'd2) begin
      errors++;
      $display("FAIL both_in_run_pause: got run=%b sec=%0d want 0 2", d_run[0], d_sec[0]);
    end
    drive(0, 0, 0, 0, 0);
    repeat (3) clk_step();
    checks++;
    if (d_run[0] !== 1'b0 || d_sec[0] !== 6'd2 || d_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL pause_hold: got run=%b sec=%0d done=%b want 0 2 0", d_run[0], d_sec[0], d_done[0]);
    end
    drive(0, 1, 1, 0, 0);
    clk_step();
    checks++;
    if (d_run[0] !== 1'b1 || d_sec[0] !== 6'd2) begin
      errors++;
      $display("FAIL resume: got run=%b sec=%0d want 1 2", d_run[0], d_sec[0]);
    end
    drive(0, 0, 0, 0, 0);
    clk_step();
    clk_step();
    checks++;
    if (d_sec[0] !== 6'd0 || d_done[0] !== 1'b1 || d_pulse[0] !== 1'b1) begin
      errors++;
      $display("FAIL resume_expire: got sec=%0d done=%b pulse=%b want 0 1 1", d_sec[0], d_done[0], d_pulse[0]);
    end
  endtask

  task automatic test_clamp_and_zero();
    drive(1, 0, 0, 62, 63);
    clk_step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (d_min[i] !== 6'd59 || d_sec[i] !== 6'd59 || d_done[i] !== 1'b0) begin
        errors++;
        $display("FAIL clamp[%0d]: got %0d:%0d done=%b want 59:59 done=0", i, d_min[i], d_sec[i], d_done[i]);
      end
    end
    drive(1, 0, 0, 0, 0);
    clk_step();
    drive(0, 1, 0, 0, 0);
    clk_step();
    checks++;
    if (d_done[0] !== 1'b1 || d_pulse[0] !== 1'b1 || d_run[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_zero: got done=%b pulse=%b run=%b want 1 1 0", d_done[0], d_pulse[0], d_run[0]);
    end
    clk_step();
    checks++;
    if (d_done[0] !== 1'b1 || d_pulse[0] !== 1'b0 || d_run[0] !== 1'b0) begin
      errors++;
      $display("FAIL done_ignores_start: got done=%b pulse=%b run=%b want 1 0 0", d_done[0], d_pulse[0], d_run[0]);
    end
    drive(1, 1, 1, 0, 7);
    clk_step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (d_done[i] !== 1'b0 || d_run[i] !== 1'b0 || d_sec[i] !== 6'd7 || d_min[i] !== 6'd0) begin
        errors++;
        $display("FAIL load_in_done[%0d]: got %0d:%0d done=%b run=%b want 0:7 done=0 run=0",
                 i, d_min[i], d_sec[i], d_done[i], d_run[i]);
      end
    end
  endtask

  task automatic test_div4();
    int exp_sec;
    drive(1, 0, 0, 0, 2);
    clk_step();
    drive(0, 1, 0, 0, 0);
    clk_step();
    drive(0, 0, 0, 0, 0);
    for (int n = 1; n <= 8; n++) begin
      clk_step();
      exp_sec = (n < 4) ? 2 : (n < 8) ? 1 : 0;
      checks++;
      if (int'(d_sec[1]) != exp_sec || d_done[1] !== (n == 8)) begin
        errors++;
        $display("FAIL div4_edge%0d: got sec=%0d done=%b want %0d %b", n, d_sec[1], d_done[1], exp_sec, n == 8);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 5, 0);
    clk_step();
    drive(0, 1, 0, 0, 0);
    clk_step();
    drive(0, 0, 0, 0, 0);
    repeat (3) clk_step();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({d_min[i], d_sec[i], d_run[i], d_done[i], d_pulse[i]} !== 15'd0) begin
        errors++;
        $display("FAIL async_reset[%0d]: got %0d:%0d run=%b done=%b pulse=%b want all 0",
                 i, d_min[i], d_sec[i], d_run[i], d_done[i], d_pulse[i]);
      end
    end
    #1 reset_n = 1'b1;
    repeat (3) clk_step();
    checks++;
    if (d_min[0] !== 6'd0 || d_sec[0] !== 6'd0 || d_run[0] !== 1'b0 || d_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle: got %0d:%0d run=%b done=%b want 0:0 0 0",
               d_min[0], d_sec[0], d_run[0], d_done[0]);
    end
  endtask

  task automatic test_random();
    bit l;
    for (int n = 0; n < 1500; n++) begin
      l = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 1) == 1)
        drive(l, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5, 0, $urandom_range(0, 12));
      else
        drive(l, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5, $urandom_range(0, 63), $urandom_range(0, 63));
      if ($urandom_range(0, 299) == 0) begin
        #2 reset_n = 1'b0;
        model_reset();
        #1 reset_n = 1'b1;
      end
      clk_step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (int'(d_min[i]) != m_rem[i] / 60 || int'(d_sec[i]) != m_rem[i] % 60 ||
            d_run[i] !== (m_st[i] == S_RUN) || d_done[i] !== m_done[i] || d_pulse[i] !== m_pulse[i]) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d: got %0d:%0d run=%b done=%b pulse=%b want %0d:%0d run=%b done=%b pulse=%b",
                   i, n, d_min[i], d_sec[i], d_run[i], d_done[i], d_pulse[i],
                   m_rem[i] / 60, m_rem[i] % 60, m_st[i] == S_RUN, m_done[i], m_pulse[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_minute();
    test_pause_resume();
    test_clamp_and_zero();
    test_div4();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICK_DIV, default 1: clk cycles per one-second tick; legal range 1 to 2^16.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 load  in  1  capture set_min/set_sec and go to IDLE.
REQ-005 set_min  in  6  preset minutes.
REQ-006 set_sec  in  6  preset seconds.
REQ-007 start  in  1  begin or resume the countdown.
REQ-008 stop  in  1  pause the countdown.
REQ-009 min  out  6  remaining minutes, 0-59, registered.
REQ-010 sec  out  6  remaining seconds, 0-59, registered.
REQ-011 running  out  1  high exactly while state is RUN.
REQ-012 done  out  1  sticky expiry flag, registered.
REQ-013 done_pulse  out  1  one-cycle strobe on entry to DONE.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, PAUSE and DONE; reset state is IDLE.
REQ-015 Priority per edge SHALL be: load, then per-state start/stop, then tick.
REQ-016 load in any state SHALL have these effects:
- next state IDLE
- min <= min(set_min,59), sec <= min(set_sec,59)
- done cleared; prescaler cleared.
REQ-017 start in IDLE or PAUSE SHALL behave as follows, even if stop is also high:
- count nonzero: go to RUN and clear the prescaler; no decrement on that edge.
- count 00:00: go directly to DONE.
REQ-018 start SHALL be ignored in RUN and DONE; leaving DONE requires load or reset.
REQ-019 stop in RUN SHALL go to PAUSE, hold min/sec, and suppress any tick on that edge; stop SHALL be ignored elsewhere.
REQ-020 In RUN the prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick = (prescaler == TICK_DIV-1); TICK_DIV=1 gives a tick every RUN cycle.
REQ-021 On a tick in RUN the count SHALL change as follows:
- sec>0: sec-1
- sec==0 and min>0: sec <= 59, min-1.
REQ-022 A tick taking the count from 00:01 to 00:00 SHALL move the state to DONE on the same edge; done and done_pulse go high after that edge.
REQ-023 done SHALL stay high in DONE until load or reset; done_pulse SHALL be high for exactly one cycle per DONE entry.
REQ-024 min and sec SHALL never leave 0-59; the count SHALL never wrap below 00:00; in DONE it holds 00:00.
REQ-025 The prescaler SHALL hold in IDLE, PAUSE and DONE.

Reset
REQ-026 reset_n low SHALL immediately force the following, independent of clk:
- state IDLE
- min=0, sec=0, running=0, done=0, done_pulse=0
- prescaler=0.
REQ-027 Reset asserted mid-RUN SHALL discard the count; after release the block stays IDLE until load and start.
REQ-028 Release of reset_n SHALL cause no transition until the first clk edge with reset_n high.

Verification
REQ-029 TICK_DIV=1, load 01:00, start at edge k -> 00:59 at k+1, 00:00 with done=1 and a single done_pulse at k+60.
REQ-030 load 00:03, start, stop asserted on the second edge in RUN -> count holds 00:02 in PAUSE; start -> 00:01 on the next tick, then 00:00 and DONE.
REQ-031 load set_min=62, set_sec=63 -> min=59, sec=59; start on 00:00 -> DONE with done_pulse one cycle and done=1.
REQ-032 TICK_DIV=4, load 00:02, start -> 00:01 four edges after entering RUN, 00:00 with done eight edges after entering RUN.
REQ-033 reset_n pulsed low mid-RUN between clk edges -> all outputs 0 asynchronously; load asserted together with stop/start in DONE -> IDLE with the new preset, done=0.
REQ-034 start and stop high together in PAUSE -> RUN; both high in RUN -> PAUSE, count unchanged on that edge.
